vic_regs: RTL and testbench
===========================

VIC_REGS -- requirements
Module: vic_regs

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port cpu_cs, input, 1 bit: access strobe, one access per asserted cycle.
REQ-004 SHALL have port cpu_we, input, 1 bit: 1 = write, 0 = read; qualified by cpu_cs.
REQ-005 SHALL have port cpu_addr, input, 4 bits: register index 0x0-0xF (CPU $9000-$900F).
REQ-006 SHALL have port cpu_din, input, 8 bits: write data.
REQ-007 SHALL have port cpu_dout, output, 8 bits: registered read data.
REQ-008 SHALL have ports vga_hs and vga_vs, inputs, 1 bit each, active-low: syncs from the video stage, used for raster counting.
REQ-009 SHALL have outputs screen_addr, char_rom_addr and color_ram_addr, 16 bits each: CPU-space base addresses.
REQ-010 SHALL have outputs xorigin, yorigin, rows and cols, 7 bits each.
REQ-011 SHALL have outputs border_color (3 bits), back_color (4 bits), aux_color (4 bits), inverted (1 bit) and chars8x16 (1 bit).
REQ-012 SHALL have output volume, 4 bits.

Function
REQ-013 SHALL hold sixteen 8-bit registers R0-RF, written with cpu_din when cpu_cs && cpu_we; the new value is visible on outputs the next cycle.
REQ-014 SHALL ignore writes to R4 and R6-R9, which are read-only.
REQ-015 SHALL decode: xorigin=R0[6:0]; yorigin=R1[6:0]; cols=R2[6:0]; rows={1'b0,R3[6:1]}; chars8x16=R3[0].
REQ-016 SHALL decode: aux_color=RE[7:4]; volume=RE[3:0]; back_color=RF[7:4]; inverted=RF[3]; border_color=RF[2:0].
REQ-017 SHALL form the 14-bit VIC screen address {R5[7:4],R2[7],9'b0} and the VIC char address {R5[3:0],10'b0}.
REQ-018 SHALL map a VIC address v[13:0] to CPU space as {~v[13],2'b00,v[12:0]} for screen_addr and char_rom_addr.
REQ-019 SHALL drive color_ram_addr = 16'h9400 when R2[7]=0 and 16'h9600 when R2[7]=1.
REQ-020 SHALL, on a read (cpu_cs && !cpu_we), load cpu_dout one cycle later; cpu_dout SHALL hold its value when no read occurs.
REQ-021 SHALL return the stored value for R0-R2, R5 and RA-RF, and return {raster[0],R3[6:0]} for R3 and raster[8:1] for R4.
REQ-022 SHALL return 8'h00 for R6-R7 (light pen) and 8'hFF for R8-R9 (paddles).
REQ-023 SHALL, for a write followed by a read of the same register on the next cycle, return the newly written value.
REQ-024 SHALL keep a 10-bit line counter that increments on each vga_hs falling edge, detected against a registered copy (1-cycle latency).
REQ-025 SHALL clear the line counter to 0 on a vga_vs falling edge, which takes priority over a simultaneous hs edge.
REQ-026 SHALL saturate the line counter at 1023 with no wrap.
REQ-027 SHALL define raster[8:0] as line_counter[9:1], one VIC line per two VGA lines.

Reset
REQ-028 SHALL, while reset is high, clear R0-RF, cpu_dout, the line counter and the sync edge registers to 0.
REQ-029 SHALL, after reset, drive all decoded outputs to values derived from zero registers: screen_addr=16'h8000, char_rom_addr=16'h8000, color_ram_addr=16'h9400, all others 0.
REQ-030 SHALL, when reset is asserted during an access, discard that access.

Configuration
REQ-031 SHALL implement the line counter and raster readback (REQ-024 to REQ-027) only when the macro VIC_RASTER_EN is defined.
REQ-032 SHALL, when VIC_RASTER_EN is undefined, instantiate no counter logic, leave vga_hs and vga_vs unused, and read R3[7] and R4 as 0.

Verification
REQ-033 SHALL check: reset, then read 0xF -> cpu_dout=8'h00; screen_addr=16'h8000; color_ram_addr=16'h9400.
REQ-034 SHALL check: write R5=8'hF0 and R2=8'h96 -> screen_addr=16'h1E00, char_rom_addr=16'h8000, cols=22, color_ram_addr=16'h9600.
REQ-035 SHALL check: write RF=8'h1B -> back_color=1, inverted=1, border_color=3; reading 0xF the next cycle -> 8'h1B.
REQ-036 SHALL check: write R4=8'h55 and then read 0x4 -> raster-derived value (8'h00 after reset with no hs edges), not 8'h55; read 0x8 -> 8'hFF.
REQ-037 SHALL check, with VIC_RASTER_EN: vs pulse then 37 hs pulses -> read 0x4=8'h09, read 0x3 bit7=0; vs and hs falling in the same cycle -> counter=0.
REQ-038 SHALL check: write R3=8'h2F -> rows=23, chars8x16=1; reset asserted mid-read -> cpu_dout=8'h00 the next cycle.

Source files
------------

// File: rtl/vic_regs.sv
// VIC-style register file: sixteen CPU-visible registers, decoded video fields and raster readback.
// Optional raster line counter is built only when VIC_RASTER_EN is defined.
module vic_regs (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  input  logic        vga_hs,
  input  logic        vga_vs,
  output logic [15:0] screen_addr,
  output logic [15:0] char_rom_addr,
  output logic [15:0] color_ram_addr,
  output logic [6:0]  xorigin,
  output logic [6:0]  yorigin,
  output logic [6:0]  rows,
  output logic [6:0]  cols,
  output logic [2:0]  border_color,
  output logic [3:0]  back_color,
  output logic [3:0]  aux_color,
  output logic        inverted,
  output logic        chars8x16,
  output logic [3:0]  volume
);

  logic [7:0]  regs [16];
  logic [8:0]  raster;
  logic [7:0]  rd_data;
  logic [13:0] screen_vic;
  logic [13:0] char_vic;
  logic        wr_allowed;

  // R4 and R6-R9 reflect hardware state, so CPU writes to them are dropped.
  always_comb begin
    wr_allowed = 1'b1;
    case (cpu_addr)
      4'h4, 4'h6, 4'h7, 4'h8, 4'h9: wr_allowed = 1'b0;
      default: wr_allowed = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
    end else if (cpu_cs && cpu_we && wr_allowed) begin
      regs[cpu_addr] <= cpu_din;
    end
  end

  always_comb begin
    rd_data = regs[cpu_addr];
    case (cpu_addr)
      4'h3:       rd_data = {raster[0], regs[3][6:0]};
      4'h4:       rd_data = raster[8:1];
      4'h6, 4'h7: rd_data = 8'h00;
      4'h8, 4'h9: rd_data = 8'hFF;
      default:    rd_data = regs[cpu_addr];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_dout <= 8'h00;
    end else if (cpu_cs && !cpu_we) begin
      cpu_dout <= rd_data;
    end
  end

`ifdef VIC_RASTER_EN
  logic       hs_q;
  logic       vs_q;
  logic [9:0] line_cnt;

  // Frame sync wins over a coincident line sync so each frame starts at line 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      line_cnt <= 10'd0;
    end else begin
      hs_q <= vga_hs;
      vs_q <= vga_vs;
      if (vs_q && !vga_vs) begin
        line_cnt <= 10'd0;
      end else if (hs_q && !vga_hs && (line_cnt != 10'd1023)) begin
        line_cnt <= line_cnt + 10'd1;
      end
    end
  end

  assign raster = line_cnt[9:1];
`else
  logic unused_sync;
  assign unused_sync = vga_hs ^ vga_vs;
  assign raster      = 9'd0;
`endif

  logic unused_regs;
  assign unused_regs = ^{regs[3][7], regs[4], regs[6], regs[7], regs[8], regs[9]};

  // VIC address space is 14 bits; bit 13 selects the CPU half it appears in.
  assign screen_vic     = {regs[5][7:4], regs[2][7], 9'b0};
  assign char_vic       = {regs[5][3:0], 10'b0};
  assign screen_addr    = {~screen_vic[13], 2'b00, screen_vic[12:0]};
  assign char_rom_addr  = {~char_vic[13], 2'b00, char_vic[12:0]};
  assign color_ram_addr = regs[2][7] ? 16'h9600 : 16'h9400;

  assign xorigin      = regs[0][6:0];
  assign yorigin      = regs[1][6:0];
  assign cols         = regs[2][6:0];
  assign rows         = {1'b0, regs[3][6:1]};
  assign chars8x16    = regs[3][0];
  assign aux_color    = regs[14][7:4];
  assign volume       = regs[14][3:0];
  assign back_color   = regs[15][7:4];
  assign inverted     = regs[15][3];
  assign border_color = regs[15][2:0];

endmodule

// File: tb/tb_vic_regs.sv
// Self-checking bench for vic_regs: per-cycle behavioural model compare plus literal spot checks.
module tb_vic_regs;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_cs = 1'b0;
  logic        cpu_we = 1'b0;
  logic [3:0]  cpu_addr = 4'h0;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  cpu_dout;
  logic        vga_hs = 1'b1;
  logic        vga_vs = 1'b1;
  logic [15:0] screen_addr, char_rom_addr, color_ram_addr;
  logic [6:0]  xorigin, yorigin, rows, cols;
  logic [2:0]  border_color;
  logic [3:0]  back_color, aux_color, volume;
  logic        inverted, chars8x16;

  vic_regs dut (
    .clk(clk), .reset(reset), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .screen_addr(screen_addr), .char_rom_addr(char_rom_addr),
    .color_ram_addr(color_ram_addr),
    .xorigin(xorigin), .yorigin(yorigin), .rows(rows), .cols(cols),
    .border_color(border_color), .back_color(back_color), .aux_color(aux_color),
    .inverted(inverted), .chars8x16(chars8x16), .volume(volume)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state: register contents, read latch, and the line count the stimulus has produced.
  int m_regs [16];
  int m_dout = 0;
  int exp_lines = 0;

  function automatic int raster_now();
`ifdef VIC_RASTER_EN
    return exp_lines / 2;
`else
    return 0;
`endif
  endfunction

  function automatic int model_read(input int a);
    int r;
    r = raster_now();
    if (a == 3) return ((r % 2) * 128) + (m_regs[3] % 128);
    if (a == 4) return (r / 2) % 256;
    if (a == 6 || a == 7) return 0;
    if (a == 8 || a == 9) return 255;
    return m_regs[a];
  endfunction

  function automatic int to_cpu(input int v);
    return (v >= 8192) ? (v - 8192) : (v + 32768);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) m_regs[i] <= 0;
      m_dout <= 0;
    end else begin
      if (cpu_cs && cpu_we && !(cpu_addr == 4 || (cpu_addr >= 6 && cpu_addr <= 9)))
        m_regs[cpu_addr] <= int'(cpu_din);
      if (cpu_cs && !cpu_we)
        m_dout <= model_read(int'(cpu_addr));
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      cmp("dout", int'(cpu_dout), m_dout);
      cmp("screen_addr", int'(screen_addr),
          to_cpu((m_regs[5] / 16) * 1024 + (m_regs[2] / 128) * 512));
      cmp("char_rom_addr", int'(char_rom_addr), to_cpu((m_regs[5] % 16) * 1024));
      cmp("color_ram_addr", int'(color_ram_addr), (m_regs[2] >= 128) ? 'h9600 : 'h9400);
      cmp("xorigin", int'(xorigin), m_regs[0] % 128);
      cmp("yorigin", int'(yorigin), m_regs[1] % 128);
      cmp("cols", int'(cols), m_regs[2] % 128);
      cmp("rows", int'(rows), (m_regs[3] % 128) / 2);
      cmp("chars8x16", int'(chars8x16), m_regs[3] % 2);
      cmp("aux_color", int'(aux_color), m_regs[14] / 16);
      cmp("volume", int'(volume), m_regs[14] % 16);
      cmp("back_color", int'(back_color), m_regs[15] / 16);
      cmp("inverted", int'(inverted), (m_regs[15] / 8) % 2);
      cmp("border_color", int'(border_color), m_regs[15] % 8);
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL lit %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    cyc();
    cpu_cs = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    cyc();
    cpu_cs = 1'b0;
  endtask

  task automatic hs_pulse();
    vga_hs = 1'b0; cyc();
    vga_hs = 1'b1; cyc();
    if (exp_lines < 1023) exp_lines++;
  endtask

  task automatic vs_pulse();
    vga_vs = 1'b0; cyc();
    vga_vs = 1'b1; cyc();
    exp_lines = 0;
  endtask

  function automatic int rast_r4(input int lines);
`ifdef VIC_RASTER_EN
    return (lines / 4) % 256;
`else
    return 0;
`endif
  endfunction

  function automatic int rast_b7(input int lines);
`ifdef VIC_RASTER_EN
    return ((lines / 2) % 2) * 128;
`else
    return 0;
`endif
  endfunction

  initial begin
    cyc();
    chk_en = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    exp_lines = 0;
    cyc();

    rd(4'hF);
    lit("reset dout", int'(cpu_dout), 'h00);
    lit("reset screen", int'(screen_addr), 'h8000);
    lit("reset char", int'(char_rom_addr), 'h8000);
    lit("reset color", int'(color_ram_addr), 'h9400);

    wr(4'h5, 8'hF0);
    wr(4'h2, 8'h96);
    lit("screen 1E00", int'(screen_addr), 'h1E00);
    lit("char 8000", int'(char_rom_addr), 'h8000);
    lit("cols 22", int'(cols), 22);
    lit("color 9600", int'(color_ram_addr), 'h9600);

    wr(4'h0, 8'hA5);
    wr(4'h1, 8'h7F);
    wr(4'hE, 8'hC9);
    lit("xorigin", int'(xorigin), 'h25);
    lit("aux", int'(aux_color), 'hC);
    lit("volume", int'(volume), 9);
    rd(4'h0);
    lit("rd R0", int'(cpu_dout), 'hA5);

    wr(4'hF, 8'h1B);
    lit("back", int'(back_color), 1);
    lit("inverted", int'(inverted), 1);
    lit("border", int'(border_color), 3);
    rd(4'hF);
    lit("rd RF after wr", int'(cpu_dout), 'h1B);

    wr(4'h4, 8'h55);
    rd(4'h4);
    lit("rd R4 read-only", int'(cpu_dout), 'h00);
    rd(4'h8);
    lit("rd R8", int'(cpu_dout), 'hFF);
    wr(4'h7, 8'h12);
    rd(4'h7);
    lit("rd R7", int'(cpu_dout), 'h00);

    wr(4'h3, 8'h2F);
    lit("rows 23", int'(rows), 23);
    lit("chars8x16", int'(chars8x16), 1);
    wr(4'h5, 8'h3C);
    lit("screen 8E00", int'(screen_addr), 'h8E00);
    lit("char 1000", int'(char_rom_addr), 'h1000);

    vs_pulse();
    for (int i = 0; i < 37; i++) hs_pulse();
    rd(4'h4);
    lit("raster 37 R4", int'(cpu_dout), rast_r4(37));
    rd(4'h3);
    lit("raster 37 R3", int'(cpu_dout), 'h2F + rast_b7(37));
    hs_pulse();
    rd(4'h3);
    lit("raster 38 R3", int'(cpu_dout), 'h2F + rast_b7(38));

    vga_hs = 1'b0; vga_vs = 1'b0; cyc();
    vga_hs = 1'b1; vga_vs = 1'b1; cyc();
    exp_lines = 0;
    for (int i = 0; i < 3; i++) hs_pulse();
    rd(4'h4);
    lit("vs prio R4", int'(cpu_dout), rast_r4(3));
    rd(4'h3);
    lit("vs prio R3", int'(cpu_dout), 'h2F + rast_b7(3));

    for (int i = 0; i < 1030; i++) hs_pulse();
    rd(4'h4);
    lit("saturate R4", int'(cpu_dout), rast_r4(1023));
    rd(4'h3);
    lit("saturate R3", int'(cpu_dout), 'h2F + rast_b7(1023));
    vs_pulse();
    rd(4'h4);
    lit("vs clear R4", int'(cpu_dout), 'h00);

    rd(4'hF);
    lit("pre-reset RF", int'(cpu_dout), 'h1B);
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 4'hF; reset = 1'b1;
    cyc();
    lit("reset mid-read", int'(cpu_dout), 'h00);
    cpu_we = 1'b1; cpu_addr = 4'h0; cpu_din = 8'h77;
    cyc();
    cpu_cs = 1'b0; cpu_we = 1'b0; reset = 1'b0;
    exp_lines = 0;
    lit("reset write dropped", int'(xorigin), 0);
    rd(4'h0);
    lit("rd R0 after reset", int'(cpu_dout), 'h00);
    cyc();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
